// File: rtl/alu_rotate_sequencer_if.sv
// Bus bundle for alu_rotate_sequencer.
// Request side: start, opd, cnt, dir, rcf, cin and wrd.
// Result side: ena, sel, d, busy, done, cout and of.
// master drives the requests and observes the results. slave is the sequencer.
interface alu_rotate_sequencer_if;
  logic        start;
  logic [15:0] opd;
  logic [4:0]  cnt;
  logic        dir;
  logic        rcf;
  logic        cin;
  logic        wrd;
  logic        ena;
  logic [3:0]  sel;
  logic        d;
  logic        busy;
  logic        done;
  logic        cout;
  logic        of;

  modport master (
    output start, opd, cnt, dir, rcf, cin, wrd,
    input  ena, sel, d, busy, done, cout, of
  );

  modport slave (
    input  start, opd, cnt, dir, rcf, cin, wrd,
    output ena, sel, d, busy, done, cout, of
  );
endinterface

// File: rtl/alu_rotate_sequencer.sv
// Multi-cycle rotate unit for ROL/ROR/RCL/RCR.
// It rotates by one bit per cycle, up to 31 bits. Byte mode uses 8 bits and word
// mode uses 16 bits. It then streams the result MSB-first into a bit-addressed
// destination register.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_rotate_sequencer_if.slave
//           start/opd/cnt/dir/rcf/cin/wrd : request inputs
//           ena/sel/d                     : destination write strobe, bit select, data
//           busy/done                     : operation status
//           cout/of                       : flags, valid from done until the next start
module alu_rotate_sequencer (
  input  logic                        clk,
  input  logic                        rst_n,
  alu_rotate_sequencer_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROT   = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t      state_reg, state_next;

  // Shadow copy of the request. It is captured once at acceptance so that later
  // input changes cannot disturb a running operation.
  logic [15:0] opd_reg;
  logic [4:0]  cnt_reg;
  logic        dir_reg;
  logic        rcf_reg;
  logic        carry_reg;
  logic        wrd_reg;
  logic        rot_any_reg;   // count was non-zero, so of is recomputed
  logic [3:0]  k_reg;         // write index, also the destination bit select
  logic        cout_reg;
  logic        of_reg;

  // Single-bit rotation of the shadow operand.
  logic        msb, lsb, fill_left, fill_right, rot_carry;
  logic [15:0] rot_val;
  logic        res_msb1, of_calc;

  // In byte mode the msb of the operand is bit 7.
  assign msb        = wrd_reg ? opd_reg[15] : opd_reg[7];
  assign lsb        = opd_reg[0];
  assign fill_left  = rcf_reg ? carry_reg : msb;
  assign fill_right = rcf_reg ? carry_reg : lsb;
  assign rot_carry  = dir_reg ? lsb : msb;

  always_comb begin
    rot_val = opd_reg;
    if (!dir_reg) begin
      if (wrd_reg) rot_val = {opd_reg[14:0], fill_left};
      else         rot_val = {opd_reg[15:8], opd_reg[6:0], fill_left};
    end else begin
      if (wrd_reg) rot_val = {fill_right, opd_reg[15:1]};
      else         rot_val = {opd_reg[15:8], fill_right, opd_reg[7:1]};
    end
  end

  // Overflow is evaluated on the final result. In the WRITE state opd_reg holds that result.
  assign res_msb1 = wrd_reg ? opd_reg[14] : opd_reg[6];
  assign of_calc  = dir_reg ? (msb ^ res_msb1) : (msb ^ carry_reg);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state and outputs
  always_comb begin
    state_next = state_reg;
    bus.ena    = 1'b0;
    bus.sel    = 4'd0;
    bus.d      = 1'b0;
    bus.busy   = 1'b1;
    bus.done   = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_next = (bus.cnt != 5'd0) ? ROT : WRITE;
      end
      ROT: begin
        if (cnt_reg == 5'd1) state_next = WRITE;
      end
      WRITE: begin
        bus.ena = 1'b1;
        bus.sel = k_reg;
        bus.d   = opd_reg[4'd15 - k_reg];
        if (k_reg == 4'd15) state_next = FIN;
      end
      FIN: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        bus.busy   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opd_reg     <= 16'd0;
      cnt_reg     <= 5'd0;
      dir_reg     <= 1'b0;
      rcf_reg     <= 1'b0;
      carry_reg   <= 1'b0;
      wrd_reg     <= 1'b0;
      rot_any_reg <= 1'b0;
      k_reg       <= 4'd0;
      cout_reg    <= 1'b0;
      of_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            opd_reg     <= bus.opd;
            cnt_reg     <= bus.cnt;
            dir_reg     <= bus.dir;
            rcf_reg     <= bus.rcf;
            carry_reg   <= bus.cin;
            wrd_reg     <= bus.wrd;
            rot_any_reg <= (bus.cnt != 5'd0);
            // A byte result lands in destination bits 7:0, so sel starts at 8.
            k_reg       <= bus.wrd ? 4'd0 : 4'd8;
          end
        end
        ROT: begin
          opd_reg   <= rot_val;
          carry_reg <= rot_carry;
          cnt_reg   <= cnt_reg - 5'd1;
        end
        WRITE: begin
          k_reg <= k_reg + 4'd1;
          // The flags are updated on the edge into FIN so they are valid together with done.
          if (k_reg == 4'd15) begin
            cout_reg <= carry_reg;
            if (rot_any_reg) of_reg <= of_calc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cout = cout_reg;
  assign bus.of   = of_reg;

endmodule

// File: tb/tb_alu_rotate_sequencer.sv
module tb_alu_rotate_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic prev_of = 1'b0;

  typedef struct {
    logic [3:0] sel;
    logic       d;
  } wr_t;
  wr_t exp_q[$];

  alu_rotate_sequencer_if bus ();

  alu_rotate_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference built from (width+1)-bit and width-bit ring rotations. The count is reduced modulo the ring size.
  task automatic model(input logic [15:0] o, input logic [4:0] c, input logic dr,
                       input logic rc, input logic ci, input logic w,
                       output logic [15:0] res, output logic co, output logic ov);
    int unsigned wd, rw, n, v, ring, r, mask;
    wd   = w ? 16 : 8;
    mask = (32'd1 << wd) - 1;
    v    = w ? {16'd0, o} : {24'd0, o[7:0]};
    ring = rc ? (v | (32'(ci) << wd)) : v;
    rw   = rc ? wd + 1 : wd;
    n    = c % rw;
    if (n == 0) r = ring;
    else if (!dr) r = ((ring << n) | (ring >> (rw - n))) & ((32'd1 << rw) - 1);
    else          r = ((ring >> n) | (ring << (rw - n))) & ((32'd1 << rw) - 1);
    if (c == 0)   co = ci;
    else if (rc)  co = r[wd];
    else          co = dr ? r[wd-1] : r[0];
    r = r & mask;
    if (c == 0)   ov = prev_of;
    else if (!dr) ov = r[wd-1] ^ co;
    else          ov = r[wd-1] ^ r[wd-2];
    res = w ? r[15:0] : {o[15:8], r[7:0]};
  endtask

  // Runs one operation: exp_q is filled when the request is driven and drained as ena pulses appear.
  // poke_cyc > 0 pulses a START (with junk operands) in that cycle.
  // rst_at > 0 asserts reset during that write.
  task automatic run_op(input string name, input logic [15:0] o, input logic [4:0] c,
                        input logic dr, input logic rc, input logic ci, input logic w,
                        input logic [15:0] exp_res, input logic exp_cout, input logic exp_of,
                        input int poke_cyc, input int rst_at);
    int  done_cyc = -1;
    int  nwr = 0;
    int  first = w ? 0 : 8;
    int  exp_done = 1 + int'(c) + (w ? 16 : 8);
    bit  aborted = 0;
    wr_t e;
    exp_q.delete();
    for (int k = first; k < 16; k++) begin
      e.sel = k[3:0];
      e.d   = exp_res[15-k];
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.opd = o; bus.cnt = c; bus.dir = dr;
    bus.rcf = rc; bus.cin = ci; bus.wrd = w;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk({name, "_busy"}, 32'(bus.busy), 32'd1);
        // Scramble the inputs. The running operation must not see them.
        bus.opd = ~o; bus.cnt = c + 5'd3; bus.dir = ~dr; bus.rcf = ~rc;
        bus.cin = ~ci; bus.wrd = ~w;
      end
      bus.start = (cyc == poke_cyc);
      if (bus.ena) begin
        nwr++;
        if (exp_q.size() == 0) chk({name, "_extra_write"}, 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk({name, "_sel"}, 32'(bus.sel), 32'(e.sel));
          chk({name, "_d"}, 32'(bus.d), 32'(e.d));
        end
        if (rst_at > 0 && nwr == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk({name, "_rst_ena"}, 32'(bus.ena), 32'd0);
          chk({name, "_rst_busy"}, 32'(bus.busy), 32'd0);
          chk({name, "_rst_flags"}, {bus.sel, bus.d, bus.cout, bus.of}, 32'd0);
          aborted = 1;
          break;
        end
      end
      if (bus.done) begin
        done_cyc = cyc;
        chk({name, "_cout"}, 32'(bus.cout), 32'(exp_cout));
        chk({name, "_of"}, 32'(bus.of), 32'(exp_of));
        break;
      end
    end
    bus.start = 1'b0;
    if (aborted) begin
      exp_q.delete();
      repeat (3) begin
        @(negedge clk);
        chk({name, "_abort_quiet"}, {bus.ena, bus.done, bus.busy}, 32'd0);
      end
      rst_n = 1'b1;
      prev_of = 1'b0;
      $display("%s: aborted by reset after %0d writes", name, nwr);
      return;
    end
    chk({name, "_done_cycle"}, done_cyc, exp_done);
    chk({name, "_nwrites"}, nwr, 16 - first);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
    chk({name, "_idle"}, {bus.busy, bus.done, bus.ena}, 32'd0);
    chk({name, "_cout_hold"}, 32'(bus.cout), 32'(exp_cout));
    prev_of = exp_of;
    $display("%s: opd=%h cnt=%0d result=%h cout=%b of=%b done@%0d",
             name, o, c, exp_res, bus.cout, bus.of, done_cyc);
  endtask

  initial begin
    logic [15:0] mres;
    logic        mco, mov;
    bus.start = 1'b0; bus.opd = 16'd0; bus.cnt = 5'd0; bus.dir = 1'b0;
    bus.rcf = 1'b0; bus.cin = 1'b0; bus.wrd = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.ena, bus.sel, bus.d, bus.busy, bus.done, bus.cout, bus.of}, 32'd0);
    rst_n = 1'b1;

    run_op("rol_w_8001", 16'h8001, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b1, 0, 0);
    run_op("rol_w_cnt0", 16'hA5A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA5A5, 1'b1, prev_of, 0, 0);
    run_op("rcr_b_0001", 16'h0001, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 0);
    run_op("ror_w_poke", 16'h0001, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 5, 0);

    model(16'h00C3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, mres, mco, mov);
    run_op("rol_b_c3", 16'h00C3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, mres, mco, mov, 0, 0);
    model(16'hBEEF, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, mres, mco, mov);
    run_op("rcr_w_31", 16'hBEEF, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, mres, mco, mov, 0, 0);
    model(16'h5A96, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, mres, mco, mov);
    run_op("ror_b_96", 16'h5A96, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, mres, mco, mov, 0, 0);

    run_op("rst_mid_write", 16'h1234, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h48D0, 1'b0, 1'b0, 0, 6);
    run_op("rcl_w_17", 16'h1234, 5'd17, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_rotate_sequencer.md
ALU_ROTATE_SEQUENCER -- requirements
Module: alu_rotate_sequencer

Interface
REQ-001 Parameters: none; widths fixed as listed below.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 START  input  1  one-cycle request; sampled only in IDLE.
REQ-005 OPD  input  16  operand; byte mode uses OPD[7:0].
REQ-006 CNT  input  5  rotate count, 0..31.
REQ-007 DIR  input  1  0 = left (ROL/RCL), 1 = right (ROR/RCR).
REQ-008 RCF  input  1  1 = rotate through carry (RCL/RCR), 0 = plain rotate.
REQ-009 CIN  input  1  carry flag in.
REQ-010 WRD  input  1  1 = 16-bit word op, 0 = 8-bit byte op.
REQ-011 ENA  output  1  write strobe to downstream bit-addressed destination register.
REQ-012 SEL  output  4  destination bit select; SEL=k writes destination bit Q[15-k].
REQ-013 D  output  1  serial data bit for the selected destination bit.
REQ-014 BUSY  output  1  high from START acceptance until DONE.
REQ-015 DONE  output  1  one-cycle completion pulse.
REQ-016 COUT  output  1  carry flag result, valid from DONE until next accepted START.
REQ-017 OF  output  1  overflow flag result, same validity as COUT.

Function
REQ-018 FSM states: IDLE, ROT, WRITE, FIN; all other encodings go to IDLE.
REQ-019 IDLE: ENA=0, BUSY=0; START=1 latches OPD, CNT, DIR, RCF, CIN, WRD into shadow regs, BUSY=1 next cycle.
REQ-020 From IDLE on START: CNT≠0 -> ROT, CNT=0 -> WRITE.
REQ-021 ROT: one single-bit rotation per cycle on the shadow operand (8 or 16 bits per WRD) plus carry; exactly CNT cycles, then WRITE.
REQ-022 ROL: new lsb = old msb, C = old msb. RCL: new lsb = C, C = old msb.
REQ-023 ROR: new msb = old lsb, C = old lsb. RCR: new msb = C, C = old lsb.
REQ-024 msb is bit 15 (word) or bit 7 (byte); in byte mode shadow bits 15:8 are not modified.
REQ-025 WRITE, word: 16 cycles, k=0..15, ENA=1, SEL=k, D=result[15-k].
REQ-026 WRITE, byte: 8 cycles, k=8..15, ENA=1, SEL=k, D=result[15-k]; destination Q[15:8] never written.
REQ-027 After last WRITE cycle -> FIN: ENA=0, DONE=1 for one cycle, COUT/OF updated, then IDLE (BUSY=0).
REQ-028 COUT = final C; CNT=0 -> COUT=CIN, OF unchanged (holds previous value).
REQ-029 OF, CNT≠0, left: msb(result) XOR COUT; right: msb(result) XOR (msb-1)(result).
REQ-030 START while BUSY=1 ignored; shadow regs and outputs undisturbed.
REQ-031 Input changes after START acceptance have no effect on the running operation.
REQ-032 ENA is high only in WRITE; SEL and D are don't-care when ENA=0 but driven to 0.
REQ-033 Latency: START at cycle 0 -> DONE at cycle 1+CNT+(16 or 8); exactly one ENA pulse per written bit.

Reset
REQ-034 RST=0 asynchronously forces IDLE, ENA=0, SEL=0, D=0, BUSY=0, DONE=0, COUT=0, OF=0, shadow regs=0.
REQ-035 Reset mid-ROT or mid-WRITE aborts with no further ENA pulses; no DONE for the aborted op.
REQ-036 After RST release, first START accepted on the first rising edge with RST=1.

Verification
REQ-037 Word ROL, OPD=0x8001, CNT=1, CIN=0 -> WRITE emits 0x0003 MSB-first on SEL 0..15; COUT=1, OF=1; DONE at cycle 18.
REQ-038 Byte RCR, OPD=0x0001, CNT=1, CIN=0 -> 8 writes SEL 8..15 of 0x00; COUT=1, OF=0; DONE at cycle 10.
REQ-039 Word ROR, OPD=0x0001, CNT=4 -> result 0x1000, COUT=0, OF=0; DONE at cycle 21; START pulsed at cycle 5 ignored.
REQ-040 Word ROL, OPD=0xA5A5, CNT=0, CIN=1 -> 16 writes of 0xA5A5, COUT=1, OF holds previous value; DONE at cycle 17.
REQ-041 Word RCL, OPD=0x1234, CNT=17, CIN=0 -> result 0x1234, COUT=0 (17-bit ring identity).
REQ-042 RST low during WRITE cycle 6 -> ENA=0 immediately, BUSY=0, no DONE; next START completes normally.
